banked_sram_ctrl: RTL and testbench
===================================

BANKED_SRAM_CTRL -- requirements
Module: banked_sram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 10 and gives the word-address width per bank (depth 2**ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and gives the word width; it SHALL be a multiple of 8 (elaboration error otherwise).
REQ-003 Parameter NUM_BANKS SHALL default to 4, range 1..16; it need not be a power of two.
REQ-004 Derived BANK_WIDTH SHALL equal max(1, $clog2(NUM_BANKS)), and BE_WIDTH SHALL equal DATA_WIDTH/8.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_bank  input  BANK_WIDTH  target bank.
REQ-011 req_addr  input  ADDR_WIDTH  word address within the bank.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 req_be  input  BE_WIDTH  byte enables for writes; ignored on reads.
REQ-014 rsp_valid  output  1  read response held in the output register.
REQ-015 rsp_ready  input  1  consumer accepts the response when rsp_valid && rsp_ready.
REQ-016 rsp_rdata  output  DATA_WIDTH  read data.
REQ-017 rsp_err  output  1  response is for an out-of-range bank.
REQ-018 init_done  output  1  memory clear complete; the block is in service.

Function
REQ-019 The FSM SHALL have two states, INIT and RUN; reset forces INIT.
REQ-020 In INIT, an address counter SHALL start at 0 and write zero to that address in every bank each cycle, incrementing by one per cycle.
REQ-021 After writing address 2**ADDR_WIDTH-1, the FSM SHALL enter RUN on the next edge; INIT lasts exactly 2**ADDR_WIDTH cycles.
REQ-022 In INIT, req_ready SHALL be 0, init_done SHALL be 0, and requests SHALL be ignored.
REQ-023 In RUN, init_done SHALL be 1 and req_ready SHALL equal !rsp_valid || rsp_ready.
REQ-024 An accepted write SHALL update only the bytes whose req_be bit is 1; bytes with req_be = 0 are unchanged.
REQ-025 Writes are posted and SHALL produce no response.
REQ-026 A write to a bank >= NUM_BANKS SHALL be silently dropped.
REQ-027 An accepted read SHALL load rsp_rdata with mem[req_bank][req_addr] and set rsp_valid on the same edge, giving one-cycle latency.
REQ-028 An accepted read to a bank >= NUM_BANKS SHALL return rsp_rdata = 0 and rsp_err = 1; a valid-bank read SHALL return rsp_err = 0.
REQ-029 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-030 rsp_valid SHALL clear on a handshake with no new read accepted on that edge.
REQ-031 A simultaneous response handshake and new read acceptance SHALL reload the output register with rsp_valid staying 1, allowing back-to-back reads at one per cycle.
REQ-032 A read accepted the cycle after a write to the same bank/address SHALL return the newly written data.
REQ-033 Only one request per cycle SHALL be possible, so no intra-cycle read/write collision exists.
REQ-034 Addresses SHALL be used modulo 2**ADDR_WIDTH, with no wrap beyond the bank.

Reset
REQ-035 Asserting reset SHALL immediately clear rsp_valid, rsp_err, rsp_rdata and init_done to 0, force req_ready to 0, and set the FSM to INIT with counter 0.
REQ-036 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear; any in-flight response is lost, and memory contents are rewritten to zero.
REQ-037 Release of reset SHALL be synchronised externally; the block needs no internal synchroniser.

Verification
REQ-038 Reset release, defaults -> init_done rises exactly 1024 cycles later; a read of bank 3 addr 0x3FF then returns 0x00000000, rsp_err = 0.
REQ-039 Write bank 1 addr 0x005 data 0xDEADBEEF be 4'b1111, then write same address 0x11223344 be 4'b0101, then read -> rsp_rdata = 0xDE22BE44 one cycle after acceptance.
REQ-040 NUM_BANKS = 3: write bank 3 addr 0 data 0xFFFFFFFF, then read bank 3 -> rsp_err = 1, rdata 0; a read of bank 0 addr 0 still returns 0.
REQ-041 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; then rsp_ready = 1 with a new read -> the next data appears next cycle, with rsp_valid never dropping.
REQ-042 Streaming 8 back-to-back reads with rsp_ready = 1 -> 8 responses on consecutive cycles, in order, and req_ready constantly 1.
REQ-043 Assert reset for 1 cycle at init counter 500 -> outputs clear immediately, and init_done rises 1024 cycles after release.

Source files
------------

// File: rtl/banked_sram_ctrl.sv
// banked_sram_ctrl: NUM_BANKS word-addressed SRAM banks behind one
// request/response port. After reset every bank is cleared to zero before
// requests are accepted; reads have one-cycle latency into a held output
// register, writes are posted with per-byte enables.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing address cnt_q in every bank, requests ignored
// ST_RUN  | in service, one request per cycle
module banked_sram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  localparam int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BANK_WIDTH-1:0] req_bank,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (DATA_WIDTH % 8 != 0) begin : g_dw_check
    $error("banked_sram_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_nb_check
    $error("banked_sram_ctrl: NUM_BANKS must be in 1..16");
  end

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  bank_ok;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;

  // Banks past NUM_BANKS are representable when NUM_BANKS is not a power of two.
  assign bank_ok   = int'(req_bank) < NUM_BANKS;
  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_write && bank_ok;
  assign rd_en     = accept && !req_write;
  assign cur_word  = bank_ok ? bank_rd[req_bank] : '0;

  // Read-modify-write merge: bytes without an enable keep their stored value.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (req_be[i]) merged_word[i*8 +: 8] = req_wdata[i*8 +: 8];
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] bank_mem [DEPTH];
    logic                  bank_we;

    assign bank_we    = wr_en && (int'(req_bank) == g);
    assign bank_rd[g] = bank_mem[req_addr];

    // Storage: zero-fill during INIT, otherwise the merged write word.
    always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
        bank_mem[cnt_q] <= '0;
      end else if (bank_we) begin
        bank_mem[req_addr] <= merged_word;
      end
    end
  end

  // Next-state: clear sequencing in INIT, output register control in RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end else begin
      if (rd_en) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cur_word;
        rsp_err_d   = !bank_ok;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any held response and restarts the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Testbench for banked_sram_ctrl: a default 4-bank instance and a 3-bank
// instance share all request inputs; a reference memory model produces the
// expected response for each accepted read, queued until the DUT answers.
module tb_banked_sram_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_bank;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        ready4, rv4, re4, done4;
  logic [31:0] rd4;
  logic        ready3, rv3, re3, done3;
  logic [31:0] rd3;

  typedef struct {
    logic [31:0] d4;
    logic        e4;
    logic [31:0] d3;
    logic        e3;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [4][1024];
  int          checks = 0;
  int          errors = 0;

  banked_sram_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready4),
    .req_write(req_write), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv4),
    .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4), .init_done(done4)
  );

  banked_sram_ctrl #(.NUM_BANKS(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
    .req_write(req_write), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv3),
    .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(re3), .init_done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 1024; a++) mdl[b][a] = '0;
  endtask

  task automatic model_write(input logic [1:0] b, input logic [9:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) mdl[b][a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic push_exp(input logic [1:0] b, input logic [9:0] a);
    exp_t e;
    e.d4 = mdl[b][a];
    e.e4 = 1'b0;
    e.d3 = (b < 2'd3) ? mdl[b][a] : 32'h0;
    e.e3 = (b == 2'd3);
    sbq.push_back(e);
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic drive_write(input logic [1:0] b, input logic [9:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_write = 1'b1; req_bank = b; req_addr = a;
    req_wdata = d; req_be = be;
    model_write(b, a, d, be);
  endtask

  task automatic drive_read(input logic [1:0] b, input logic [9:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_bank = b; req_addr = a;
    req_wdata = $urandom; req_be = 4'($urandom);
    push_exp(b, a);
  endtask

  task automatic test_reset();
    drive_idle();
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({done4, ready4, rv4, re4, done3, ready3, rv3, re3} !== 8'h00 || rd4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done/ready/valid/err=%b%b%b%b %b%b%b%b rdata=%h, required all 0",
               done4, ready4, rv4, re4, done3, ready3, rv3, re3, rd4);
    end
    req_valid = 1'b1; req_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready4, ready3, rv4, rv3} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ignore_req: ready=%b/%b valid=%b/%b, required 0", ready4, ready3, rv4, rv3);
    end
  endtask

  task automatic test_init();
    int   n;
    int   bad;
    exp_t e;
    n = 0; bad = 0;
    req_valid = 1'b1; req_write = 1'b1; req_bank = 2'd1; req_addr = 10'h005;
    req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    @(negedge clk) reset = 1'b0;
    while (done4 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (done4 !== 1'b1 && (ready4 !== 1'b0 || ready3 !== 1'b0 || done3 !== 1'b0)) bad++;
    end
    checks++;
    if (n != 1024 || done3 !== 1'b1) begin
      errors++;
      $display("FAIL init_length: init_done after %0d cycles (3-bank done=%b), required 1024", n, done3);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_busy: %0d INIT cycles with ready or init_done set, required 0", bad);
    end
    drive_read(2'd3, 10'h3FF);
    @(posedge clk); #1;
    drive_read(2'd1, 10'h005);
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL init_read_3ff: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL init_ignored_write: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_enable();
    exp_t e;
    drive_write(2'd1, 10'h005, 32'hDEAD_BEEF, 4'b1111);
    @(posedge clk); #1;
    drive_write(2'd1, 10'h005, 32'h1122_3344, 4'b0101);
    @(posedge clk); #1;
    drive_read(2'd1, 10'h005);
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL be_merge_model: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    checks++;
    if (rd4 !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL be_merge_value: rdata=%h, required de22be44", rd4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    drive_write(2'd3, 10'h000, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    drive_read(2'd3, 10'h000);
    @(posedge clk); #1;
    drive_read(2'd0, 10'h000);
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL oob_read: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    checks++;
    if (re3 !== 1'b1 || rd3 !== 32'h0) begin
      errors++;
      $display("FAIL oob_err_flag: err=%b rdata=%h, required err=1 rdata=0", re3, rd3);
    end
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL oob_bank0_read: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    exp_t eh;
    exp_t e;
    drive_write(2'd2, 10'h020, 32'hA5A5_0001, 4'hF);
    @(posedge clk); #1;
    drive_write(2'd2, 10'h021, 32'h5A5A_0002, 4'hF);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_read(2'd2, 10'h020);
    @(posedge clk); #1;
    eh = sbq.pop_front();
    drive_read(2'd2, 10'h021);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({rv4, rv3} !== 2'b11 || rd4 !== eh.d4 || rd3 !== eh.d3 || re4 !== eh.e4 ||
          re3 !== eh.e3 || {ready4, ready3} !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b/%b d=%h/%h ready=%b/%b, required v=1 d=%h/%h ready=0",
                 c, rv4, rv3, rd4, rd3, ready4, ready3, eh.d4, eh.d3);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({ready4, ready3} !== 2'b11) begin
      errors++;
      $display("FAIL stall_release_ready: ready=%b/%b, required 1", ready4, ready3);
    end
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL stall_next_read: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive_write(2'd2, 10'(16 + i), {8'(8'hA0 + i), 24'($urandom)}, 4'hF);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      drive_read(2'd2, 10'(16 + i));
      #1;
      checks++;
      if ({ready4, ready3} !== 2'b11) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b/%b, required 1", i, ready4, ready3);
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
                 i, rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
      end
    end
    drive_idle();
    @(posedge clk); #1;
    checks++;
    if ({rv4, rv3} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b/%b after handshake with no new read, required 0", rv4, rv3);
    end
  endtask

  task automatic test_random();
    logic pend;
    logic acc;
    logic rr;
    logic expr;
    pend = 1'b0;
    for (int c = 0; c < 120; c++) begin
      rr        = ($urandom_range(0, 3) != 0);
      rsp_ready = rr;
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_bank  = 2'($urandom_range(0, 3));
      req_addr  = 10'($urandom_range(64, 71));
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      expr      = !pend || rr;
      acc       = req_valid && expr;
      #1;
      checks++;
      if (ready4 !== expr || ready3 !== expr) begin
        errors++;
        $display("FAIL rand_ready[%0d]: ready=%b/%b, required %b", c, ready4, ready3, expr);
      end
      if (acc && req_write) model_write(req_bank, req_addr, req_wdata, req_be);
      if (acc && !req_write) push_exp(req_bank, req_addr);
      @(posedge clk); #1;
      if (pend && rr) void'(sbq.pop_front());
      if (acc && !req_write) pend = 1'b1;
      else if (pend && rr) pend = 1'b0;
      checks++;
      if (pend) begin
        if ({rv4, rv3} !== 2'b11 || rd4 !== sbq[0].d4 || re4 !== sbq[0].e4 ||
            rd3 !== sbq[0].d3 || re3 !== sbq[0].e3) begin
          errors++;
          $display("FAIL rand_rsp[%0d]: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
                   c, rv4, rv3, rd4, rd3, re4, re3, sbq[0].d4, sbq[0].d3, sbq[0].e4, sbq[0].e3);
        end
      end else if ({rv4, rv3} !== 2'b00) begin
        errors++;
        $display("FAIL rand_idle[%0d]: valid=%b/%b, required 0", c, rv4, rv3);
      end
    end
    drive_idle();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
  endtask

  task automatic test_reset_recover();
    exp_t e;
    int   n;
    rsp_ready = 1'b0;
    drive_read(2'd1, 10'h005);
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || rd3 !== e.d3) begin
      errors++;
      $display("FAIL rst_pending_rsp: v=%b/%b d=%h/%h, required v=1 d=%h/%h",
               rv4, rv3, rd4, rd3, e.d4, e.d3);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rv4, re4, done4, ready4, rv3, re3, done3, ready3} !== 8'h00 ||
        rd4 !== 32'h0 || rd3 !== 32'h0) begin
      errors++;
      $display("FAIL rst_run_clear: v/e/done/ready=%b%b%b%b %b%b%b%b d=%h/%h, required all 0",
               rv4, re4, done4, ready4, rv3, re3, done3, ready3, rd4, rd3);
    end
    clear_model();
    rsp_ready = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({done4, ready4, rv4, done3, ready3, rv3} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_mid_init: done/ready/valid=%b%b%b %b%b%b, required 0",
               done4, ready4, rv4, done3, ready3, rv3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 1024 || done3 !== 1'b1) begin
      errors++;
      $display("FAIL rst_init_length: init_done after %0d cycles (3-bank done=%b), required 1024", n, done3);
    end
    drive_read(2'd1, 10'h005);
    @(posedge clk); #1;
    drive_read(2'd2, 10'h010);
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL rst_recleared_a: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
    drive_idle();
    e = sbq.pop_front();
    checks++;
    if ({rv4, rv3} !== 2'b11 || rd4 !== e.d4 || re4 !== e.e4 || rd3 !== e.d3 || re3 !== e.e3) begin
      errors++;
      $display("FAIL rst_recleared_b: v=%b/%b d=%h/%h e=%b/%b, required v=1 d=%h/%h e=%b/%b",
               rv4, rv3, rd4, rd3, re4, re3, e.d4, e.d3, e.e4, e.e3);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_model();
    test_reset();
    test_init();
    test_byte_enable();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_recover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
